pipe_perf_monitor: RTL and testbench

- Synthesizable performance-event monitor that attaches beside the 5-stage pipelined CPU.
- Counts elapsed cycles plus N_EVT independent, pre-qualified event lines (e.g. stall, flush, retire, load-use).
- Supports an optional cycle limit, an atomic snapshot of all counters, and a registered read port, so stall/flush statistics come from hardware instead of bench-side probing.
- Generalises per-event counting to parametrised width, channel count and overflow mode.

---
 rtl/pipe_perf_monitor.sv | 139 +++++++++++++
 tb/tb_pipe_perf_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: cycle/event performance counters with an atomic snapshot bank and registered read port.
// Defining PERF_PC_TRACE_EN adds a circular buffer of PCs captured on the flush channel (evt_i[1]).
module pipe_perf_monitor #(
   parameter int CNT_W       = 32,
   parameter int N_EVT       = 4,
   parameter int SATURATE    = 1,
   parameter int TRACE_DEPTH = 8
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             start_i,
   input  logic                             clear_i,
   input  logic [CNT_W-1:0]                 limit_i,
   input  logic [N_EVT-1:0]                 evt_i,
   input  logic                             snap_i,
   input  logic [3:0]                       rd_sel_i,
   output logic [CNT_W-1:0]                 rd_data_o,
   output logic                             running_o,
   output logic                             done_o,
   output logic [N_EVT:0]                   ovf_o
`ifdef PERF_PC_TRACE_EN
   ,
   input  logic [31:0]                      pc_i,
   input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_sel_i,
   output logic [31:0]                      trace_pc_o,
   output logic [$clog2(TRACE_DEPTH):0]     trace_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   localparam int NC = N_EVT + 1;

   stateT            r_state;
   logic             r_running;
   logic             r_done;
   logic [CNT_W-1:0] r_cnt    [NC];
   logic [CNT_W-1:0] r_shadow [NC];
   logic [CNT_W-1:0] r_rdData;
   logic [NC-1:0]    r_ovf;
   logic [NC-1:0]    w_inc;
   logic             w_hitLimit;
   logic [CNT_W-1:0] w_rdMux;

   // Slot 0 is the cycle counter, slot k+1 is event channel k.
   assign w_inc = (r_state == RUN) ? {evt_i, 1'b1} : '0;

   // Once the cycle counter has overflowed the limit is considered passed and never fires.
   assign w_hitLimit = (r_state == RUN) && (limit_i != '0) && !r_ovf[0] &&
                       ((r_cnt[0] + CNT_W'(1)) == limit_i);

   always_comb begin
      w_rdMux = '0;
      for (int k = 0; k < NC; k++) begin
         if (rd_sel_i == 4'(k)) w_rdMux = r_shadow[k];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_state   <= IDLE;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_rdData  <= '0;
         r_ovf     <= '0;
         for (int k = 0; k < NC; k++) begin
            r_cnt[k]    <= '0;
            r_shadow[k] <= '0;
         end
      end else begin
         r_rdData <= w_rdMux;
         for (int k = 0; k < NC; k++) begin
            if (snap_i) r_shadow[k] <= r_cnt[k];
            if (w_inc[k]) begin
               if (r_cnt[k] == '1) begin
                  r_ovf[k] <= 1'b1;
                  r_cnt[k] <= (SATURATE != 0) ? '1 : '0;
               end else begin
                  r_cnt[k] <= r_cnt[k] + CNT_W'(1);
               end
            end
         end
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
            end
            RUN: begin
               if (w_hitLimit) begin
                  r_state   <= DONE;
                  r_running <= 1'b0;
                  r_done    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rd_data_o = r_rdData;
   assign running_o = r_running;
   assign done_o    = r_done;
   assign ovf_o     = r_ovf;

`ifdef PERF_PC_TRACE_EN
   localparam int TR_W = $clog2(TRACE_DEPTH);

   logic [31:0]     r_trace [TRACE_DEPTH];
   logic [TR_W-1:0] r_wrPtr;
   logic [TR_W:0]   r_traceCnt;
   logic [31:0]     r_tracePc;
   logic [TR_W-1:0] w_rdIdx;

   // Select 0 is the newest entry, i.e. the slot just behind the write pointer.
   assign w_rdIdx = r_wrPtr - TR_W'(1) - trace_sel_i;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_wrPtr    <= '0;
         r_traceCnt <= '0;
         r_tracePc  <= '0;
         for (int k = 0; k < TRACE_DEPTH; k++) r_trace[k] <= '0;
      end else begin
         r_tracePc <= r_trace[w_rdIdx];
         if ((r_state == RUN) && evt_i[1]) begin
            r_trace[r_wrPtr] <= pc_i;
            r_wrPtr          <= r_wrPtr + TR_W'(1);
            if (r_traceCnt != (TR_W+1)'(TRACE_DEPTH)) r_traceCnt <= r_traceCnt + (TR_W+1)'(1);
         end
      end
   end

   assign trace_pc_o  = r_tracePc;
   assign trace_cnt_o = r_traceCnt;
`endif

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb_pipe_perf_monitor: drives a saturating and a wrapping 8-bit instance with identical stimulus and
// checks both against an unbounded-count reference model of the monitor.
module tb_pipe_perf_monitor;

   localparam int W  = 8;
   localparam int NE = 4;

   logic          clk = 1'b0;
   logic          rst, start, clear, snap;
   logic [W-1:0]  limit;
   logic [NE-1:0] evt;
   logic [3:0]    rdSel;
   logic [W-1:0]  rdSat, rdWrap;
   logic          runSat, runWrap, doneSat, doneWrap;
   logic [NE:0]   ovfSat, ovfWrap;
`ifdef PERF_PC_TRACE_EN
   logic [31:0]   pc;
   logic [2:0]    traceSel;
   logic [31:0]   tracePcSat, tracePcWrap;
   logic [3:0]    traceCntSat, traceCntWrap;
`endif

   int nChecks = 0;
   int nErrors = 0;

   // Reference model: true (unbounded) counts; each DUT's view is derived from them.
   int     mState;
   longint mCnt    [NE+1];
   longint mShadow [NE+1];
   longint mRd;

   always #5 clk = ~clk;

   pipe_perf_monitor #(.CNT_W(W), .N_EVT(NE), .SATURATE(1), .TRACE_DEPTH(8)) dutSat (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .limit_i(limit),
      .evt_i(evt), .snap_i(snap), .rd_sel_i(rdSel), .rd_data_o(rdSat),
      .running_o(runSat), .done_o(doneSat), .ovf_o(ovfSat)
`ifdef PERF_PC_TRACE_EN
      , .pc_i(pc), .trace_sel_i(traceSel), .trace_pc_o(tracePcSat), .trace_cnt_o(traceCntSat)
`endif
   );

   pipe_perf_monitor #(.CNT_W(W), .N_EVT(NE), .SATURATE(0), .TRACE_DEPTH(8)) dutWrap (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .limit_i(limit),
      .evt_i(evt), .snap_i(snap), .rd_sel_i(rdSel), .rd_data_o(rdWrap),
      .running_o(runWrap), .done_o(doneWrap), .ovf_o(ovfWrap)
`ifdef PERF_PC_TRACE_EN
      , .pc_i(pc), .trace_sel_i(traceSel), .trace_pc_o(tracePcWrap), .trace_cnt_o(traceCntWrap)
`endif
   );

   function automatic logic [W-1:0] view(input longint v, input bit sat);
      if (sat) return (v > 255) ? 8'hFF : 8'(v);
      return 8'(v % 256);
   endfunction

   function automatic logic [NE:0] ovfExp();
      logic [NE:0] r;
      for (int k = 0; k <= NE; k++) r[k] = (mCnt[k] > 255);
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("runSat",   32'(runSat),   32'(mState == 1));
      checkOutput("runWrap",  32'(runWrap),  32'(mState == 1));
      checkOutput("doneSat",  32'(doneSat),  32'(mState == 2));
      checkOutput("doneWrap", 32'(doneWrap), 32'(mState == 2));
      checkOutput("ovfSat",   32'(ovfSat),   32'(ovfExp()));
      checkOutput("ovfWrap",  32'(ovfWrap),  32'(ovfExp()));
      checkOutput("rdSat",    32'(rdSat),    32'(view(mRd, 1)));
      checkOutput("rdWrap",   32'(rdWrap),   32'(view(mRd, 0)));
   endtask

   task automatic modelClear();
      mState = 0;
      mRd    = 0;
      for (int k = 0; k <= NE; k++) begin
         mCnt[k]    = 0;
         mShadow[k] = 0;
      end
   endtask

   task automatic doReset();
      rst = 1'b1; start = 1'b0; clear = 1'b0; snap = 1'b0; evt = '0; rdSel = '0; limit = '0;
      @(posedge clk);
      modelClear();
      #1;
      rst = 1'b0;
      checkAll();
   endtask

   // One clock: drive inputs, advance the model with what the DUT samples, then check.
   task automatic applyStimulus(input bit iStart, input bit iClear, input bit iSnap,
                                input logic [NE-1:0] iEvt, input logic [3:0] iSel);
      start = iStart; clear = iClear; snap = iSnap; evt = iEvt; rdSel = iSel;
      @(posedge clk);
      if (iClear) begin
         modelClear();
      end else begin
         mRd = (iSel <= NE) ? mShadow[iSel] : 0;
         if (iSnap) for (int k = 0; k <= NE; k++) mShadow[k] = mCnt[k];
         if (mState == 0) begin
            if (iStart) mState = 1;
         end else if (mState == 1) begin
            if (limit != 0 && mCnt[0] + 1 == longint'(limit)) mState = 2;
            mCnt[0]++;
            for (int k = 0; k < NE; k++) mCnt[k+1] += iEvt[k];
         end
      end
      #1;
      checkAll();
   endtask

   initial begin
      int doneAt;
`ifdef PERF_PC_TRACE_EN
      pc = '0; traceSel = '0;
`endif
      doReset();

      $display("[TB] idle with all events high");
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 4'b1111, 4'd0);
      applyStimulus(0, 0, 1, 4'b1111, 4'd1);
      for (int s = 0; s <= NE; s++) applyStimulus(0, 0, 0, 4'b1111, 4'(s));

      $display("[TB] limit 64 run");
      limit  = 8'd64;
      doneAt = 0;
      applyStimulus(1, 0, 0, 4'b0000, 4'd0);
      for (int i = 1; i <= 80; i++) begin
         applyStimulus(0, 0, 0, {2'b00, (i % 20 == 5) && (i <= 64), (i % 6 == 2) && (i < 60)}, 4'd0);
         if (doneSat && doneAt == 0) doneAt = i;
      end
      checkOutput("doneLatency", 32'(doneAt), 32'd64);
      applyStimulus(0, 0, 1, 4'b0000, 4'd0);
      applyStimulus(0, 0, 0, 4'b0000, 4'd0);
      checkOutput("cycles64", 32'(rdSat), 32'd64);
      applyStimulus(0, 0, 0, 4'b0000, 4'd1);
      checkOutput("evt0Ten", 32'(rdSat), 32'd10);
      applyStimulus(0, 0, 0, 4'b0000, 4'd2);
      checkOutput("evt1Three", 32'(rdWrap), 32'd3);

      $display("[TB] reset from a populated state");
      doReset();

      $display("[TB] overflow with evt0 held 300 cycles");
      limit = '0;
      applyStimulus(1, 0, 0, 4'b0000, 4'd0);
      for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0, 4'b0001, 4'd1);
      applyStimulus(0, 0, 1, 4'b0000, 4'd1);
      applyStimulus(0, 0, 0, 4'b0000, 4'd1);
      checkOutput("satEvt0", 32'(rdSat), 32'd255);
      checkOutput("wrapEvt0", 32'(rdWrap), 32'd44);
      checkOutput("ovfSatBit1", 32'(ovfSat[1]), 32'd1);
      checkOutput("ovfWrapBit1", 32'(ovfWrap[1]), 32'd1);

      $display("[TB] snapshot coincident with event");
      applyStimulus(0, 1, 0, 4'b0000, 4'd0);
      applyStimulus(1, 0, 0, 4'b0000, 4'd0);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 4'b0100, 4'd0);
      applyStimulus(0, 0, 1, 4'b0100, 4'd3);
      applyStimulus(0, 0, 0, 4'b0000, 4'd3);
      checkOutput("snapPreInc", 32'(rdSat), 32'd7);
      applyStimulus(0, 0, 1, 4'b0000, 4'd3);
      applyStimulus(0, 0, 0, 4'b0000, 4'd3);
      checkOutput("snapPostInc", 32'(rdSat), 32'd8);

      $display("[TB] clear with start and snap");
      applyStimulus(0, 1, 1, 4'b1111, 4'd0);
      checkOutput("clearNoRun", 32'(runSat), 32'd0);
      for (int s = 0; s <= NE; s++) applyStimulus(0, 0, 0, 4'b1111, 4'(s));

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 29) == 0) limit = 8'($urandom_range(0, 120));
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                       4'($urandom), 4'($urandom));
      end

`ifdef PERF_PC_TRACE_EN
      $display("[TB] PC trace");
      limit = '0;
      applyStimulus(0, 1, 0, 4'b0000, 4'd0);
      applyStimulus(1, 0, 0, 4'b0000, 4'd0);
      for (int i = 1; i <= 10; i++) begin
         pc = 32'(4 * i);
         applyStimulus(0, 0, 0, 4'b0010, 4'd0);
      end
      traceSel = 3'd0;
      applyStimulus(0, 0, 0, 4'b0000, 4'd0);
      checkOutput("traceCnt", 32'(traceCntSat), 32'd8);
      checkOutput("traceNewest", tracePcSat, 32'h28);
      traceSel = 3'd7;
      applyStimulus(0, 0, 0, 4'b0000, 4'd0);
      checkOutput("traceOldest", tracePcWrap, 32'h0C);
`endif

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
